// File: rtl/controller.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, jump/branch flushes
// and a RUN/DRAIN/REDIRECT sequencer that drains the pipe before redirecting to the trap vector.
module controller (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [4:0] rs1_addr_id_i,
   input  logic [4:0] rs2_addr_id_i,
   input  logic [4:0] rd_addr_ex_i,
   input  logic [4:0] rd_addr_mem_i,
   input  logic [4:0] rd_addr_wb_i,
   input  logic       reg_alu_wen_ex_i,
   input  logic       reg_alu_wen_mem_i,
   input  logic       reg_alu_wen_wb_i,
   input  logic       reg_mem_wen_ex_i,
   input  logic       reg_mem_wen_mem_i,
   input  logic       reg_mem_wen_wb_i,
   input  logic       jump_id_i,
   input  logic       branch_taken_ex_i,
   input  logic       trap_id_i,
   output logic [2:0] fwd_op1_id_o,
   output logic [2:0] fwd_op2_id_o,
   output logic       stall_if_o,
   output logic       stall_id_o,
   output logic       flush_id_o,
   output logic       flush_ex_o,
   output logic       trap_redirect_o,
   output logic [1:0] ctrl_state_o
);

   localparam logic [2:0] FwdNone     = 3'd0;
   localparam logic [2:0] FwdExAlu    = 3'd1;
   localparam logic [2:0] FwdMemAlu   = 3'd2;
   localparam logic [2:0] FwdMemRdata = 3'd3;
   localparam logic [2:0] FwdWbAlu    = 3'd4;
   localparam logic [2:0] FwdWbRdata  = 3'd5;

   typedef enum logic [1:0] {
      StRun      = 2'd0,
      StDrain    = 2'd1,
      StRedirect = 2'd2
   } ctrl_state_e;

   ctrl_state_e state_q, state_d;
   logic [1:0]  drain_cnt_q, drain_cnt_d;

   logic [2:0]  fwd_op1_raw, fwd_op2_raw;
   logic        load_use_op1, load_use_op2, load_use;

   // A load still in EX has no data yet: that operand selects nothing and the pipe stalls.
   function automatic logic [2:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_ex,
      input logic       alu_ex,
      input logic       mem_ex,
      input logic [4:0] rd_mem,
      input logic       alu_mem,
      input logic       mem_mem,
      input logic [4:0] rd_wb,
      input logic       alu_wb,
      input logic       mem_wb
   );
      logic [2:0] sel;
      sel = FwdNone;
      if (rs != 5'd0) begin
         if ((rs == rd_ex) && (alu_ex || mem_ex)) begin
            sel = mem_ex ? FwdNone : FwdExAlu;
         end else if ((rs == rd_mem) && (alu_mem || mem_mem)) begin
            sel = mem_mem ? FwdMemRdata : FwdMemAlu;
         end else if ((rs == rd_wb) && (alu_wb || mem_wb)) begin
            sel = mem_wb ? FwdWbRdata : FwdWbAlu;
         end
      end
      return sel;
   endfunction

   assign fwd_op1_raw = fwd_sel(rs1_addr_id_i, rd_addr_ex_i, reg_alu_wen_ex_i, reg_mem_wen_ex_i,
                                rd_addr_mem_i, reg_alu_wen_mem_i, reg_mem_wen_mem_i,
                                rd_addr_wb_i, reg_alu_wen_wb_i, reg_mem_wen_wb_i);
   assign fwd_op2_raw = fwd_sel(rs2_addr_id_i, rd_addr_ex_i, reg_alu_wen_ex_i, reg_mem_wen_ex_i,
                                rd_addr_mem_i, reg_alu_wen_mem_i, reg_mem_wen_mem_i,
                                rd_addr_wb_i, reg_alu_wen_wb_i, reg_mem_wen_wb_i);

   assign load_use_op1 = (rs1_addr_id_i != 5'd0) && (rs1_addr_id_i == rd_addr_ex_i) &&
                         reg_mem_wen_ex_i;
   assign load_use_op2 = (rs2_addr_id_i != 5'd0) && (rs2_addr_id_i == rd_addr_ex_i) &&
                         reg_mem_wen_ex_i;
   assign load_use     = load_use_op1 || load_use_op2;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= StRun;
         drain_cnt_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         StRun: begin
            // A taken branch squashes the trapping instruction in ID.
            if (trap_id_i && !branch_taken_ex_i) begin
               state_d     = StDrain;
               drain_cnt_d = 2'd2;
            end
         end
         StDrain: begin
            if (drain_cnt_q == 2'd0) begin
               state_d = StRedirect;
            end else begin
               drain_cnt_d = drain_cnt_q - 2'd1;
            end
         end
         StRedirect: begin
            state_d = StRun;
         end
         default: begin
            state_d     = StRun;
            drain_cnt_d = 2'd0;
         end
      endcase
   end

   always_comb begin
      fwd_op1_id_o    = FwdNone;
      fwd_op2_id_o    = FwdNone;
      stall_if_o      = 1'b0;
      stall_id_o      = 1'b0;
      flush_id_o      = 1'b0;
      flush_ex_o      = 1'b0;
      trap_redirect_o = 1'b0;
      unique case (state_q)
         StRun: begin
            fwd_op1_id_o = fwd_op1_raw;
            fwd_op2_id_o = fwd_op2_raw;
            if (branch_taken_ex_i) begin
               flush_id_o = 1'b1;
               flush_ex_o = 1'b1;
            end else if (load_use) begin
               stall_if_o = 1'b1;
               stall_id_o = 1'b1;
               flush_ex_o = 1'b1;
            end else if (jump_id_i) begin
               flush_id_o = 1'b1;
            end
         end
         StDrain: begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            flush_ex_o = 1'b1;
         end
         StRedirect: begin
            trap_redirect_o = 1'b1;
            flush_id_o      = 1'b1;
            flush_ex_o      = 1'b1;
         end
         default: ;
      endcase
   end

   assign ctrl_state_o = state_q;

endmodule
